// File: rtl/fetch.sv
// RV32I instruction-fetch stage: PC ownership, credit-limited imem requests, in-order return queue.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic        fetch_err
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]          r_pc_q;
  logic [31:0]          r_qpc   [BUF_DEPTH];
  logic [31:0]          r_qinst [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_filled;
  logic [AW-1:0]        r_head, r_tail, r_fptr;
  logic [CW-1:0]        r_count, r_inflight;
  logic [7:0]           r_drop;
  logic                 r_halted, r_err;

  logic        w_valid, w_pop, w_req, w_grant, w_rsp_drop, w_rsp_fill, w_misalign;
  logic [CW-1:0] w_occ;
  logic [31:0] w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc = redirect_pc;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_misalign   = 1'b0;
  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
`endif

  // r_count counts every allocated entry, so it already equals filled + inflight.
  assign w_valid    = !rst && !r_halted && r_filled[r_head];
  assign w_pop      = w_valid && decode_ready && !stall && !redirect_valid;
  assign w_occ      = r_count - CW'(w_pop);
  assign w_req      = !rst && !stall && !redirect_valid && !r_halted && (w_occ < CW'(BUF_DEPTH));
  assign w_grant    = w_req && imem_gnt;
  assign w_rsp_drop = imem_rvalid && (r_drop != 8'd0);
  assign w_rsp_fill = imem_rvalid && (r_drop == 8'd0) && (r_inflight != '0);

  assign imem_req    = w_req;
  assign imem_addr   = r_pc_q;
  assign fetch_valid = w_valid;
  assign fetch_err   = r_err;
  assign pc_out      = rst ? '0 : (r_halted ? r_pc_q : r_qpc[r_head]);
  assign inst_out    = (rst || r_halted) ? '0 : r_qinst[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_q     <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_fptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_filled   <= '0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
    end else if (redirect_valid) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_filled   <= '0;
      // Everything still outstanding after this cycle gets discarded.
      r_drop     <= r_drop + 8'(r_inflight) - 8'(w_rsp_drop | w_rsp_fill);
      if (!r_halted) begin
        r_pc_q <= w_redir_pc;
        if (w_misalign) begin
          r_halted <= 1'b1;
          r_err    <= 1'b1;
        end
      end
    end else begin
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + AW'(1);
      end
      if (w_grant) begin
        r_qpc[r_tail]    <= r_pc_q;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + AW'(1);
        r_pc_q           <= r_pc_q + 32'd4;
      end
      if (w_rsp_fill) begin
        r_qinst[r_fptr]  <= imem_rdata;
        r_filled[r_fptr] <= 1'b1;
        r_fptr           <= r_fptr + AW'(1);
      end
      if (w_rsp_drop)
        r_drop <= r_drop - 8'd1;
      r_count    <= r_count + CW'(w_grant) - CW'(w_pop);
      r_inflight <= r_inflight + CW'(w_grant) - CW'(w_rsp_fill);
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed table-driven bench for fetch with a fixed-latency in-order memory model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_gnt, decode_ready;
  logic [31:0] redirect_pc;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        imem_req, fetch_valid, fetch_err;
  logic [31:0] imem_addr, pc_out, inst_out;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .inst_out(inst_out), .fetch_valid(fetch_valid),
    .decode_ready(decode_ready), .fetch_err(fetch_err)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: responds mem_lat cycles after the grant, strictly in order.
  int unsigned mem_lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      cyc = 0;
      imem_rvalid <= 1'b0;
    end else begin
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + int'(mem_lat));
      end
      cyc++;
      if (mq_due.size() > 0 && mq_due[0] == cyc) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mdata(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  typedef struct {
    bit          stall;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    bit          err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  int cnum   = 0;

  function automatic vec_t mk(bit st, bit rd, bit rv, logic [31:0] rp,
                              bit rq, logic [31:0] ad, bit vl, logic [31:0] pc, bit er);
    vec_t v;
    v.stall = st; v.ready = rd; v.redir = rv; v.rpc = rp;
    v.req = rq; v.addr = ad; v.valid = vl; v.pc = pc; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cnum, act, exp);
    end
  endtask

  // Called at a negedge; applies inputs, samples 1 time unit later, then moves to the next negedge.
  task automatic run_vec(input vec_t v);
    stall          = v.stall;
    decode_ready   = v.ready;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, v.req});
    if (v.req) chk("imem_addr", imem_addr, v.addr);
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, v.valid});
    if (v.valid || v.err) chk("pc_out", pc_out, v.pc);
    if (v.valid) chk("inst_out", inst_out, mdata(v.pc));
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, v.err});
    @(negedge clk);
    cnum++;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset(input int unsigned lat);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; decode_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_lat = lat;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    cnum = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; decode_ready = 1'b1; imem_gnt = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Streaming, decode back-pressure, stall with a response landing, redirect to wrap point.
    do_reset(1);
    tbl.push_back(mk(0,1,0,0, 1,32'h100, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h104, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h108, 1,32'h100, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h10C, 1,32'h104, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0, 0,0, 1,32'h108, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h110, 1,32'h108, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h114, 1,32'h10C, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h118, 1,32'h110, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h11C, 1,32'h114, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,1,0,0, 0,0, 1,32'h118, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h120, 1,32'h118, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h124, 1,32'h11C, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h128, 1,32'h120, 0));
    tbl.push_back(mk(0,1,1,32'hFFFF_FFFC, 0,0, 1,32'h124, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'hFFFF_FFFC, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0000_0000, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0000_0004, 1,32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0000_0008, 1,32'h0000_0000, 0));
    run_tbl();

    // 3-cycle memory, two stale responses in flight at the redirect.
    do_reset(3);
    tbl.push_back(mk(0,1,0,0, 1,32'h100, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h104, 0,0, 0));
    tbl.push_back(mk(0,1,1,32'h200, 0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h200, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h204, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h208, 1,32'h200, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h20C, 1,32'h204, 0));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h210, 1,32'h208, 0));
    run_tbl();

    // Misaligned redirect, with one response returning in the redirect cycle.
    do_reset(1);
    tbl.push_back(mk(0,1,0,0, 1,32'h100, 0,0, 0));
    tbl.push_back(mk(0,1,1,32'h202, 0,0, 0,0, 0));
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,0, 0,0, 0,32'h202, 1));
`else
    tbl.push_back(mk(0,1,0,0, 1,32'h200, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h204, 0,0, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h208, 1,32'h200, 0));
    tbl.push_back(mk(0,1,0,0, 1,32'h20C, 1,32'h204, 0));
`endif
    run_tbl();

    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
